// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the guessing-round controller.
//   state_t    - round FSM states, values are the externally visible state_o codes
//   CODE_*     - special seven-segment display codes (hex nibble n is code n+1)
//   nib2code   - nibble to display code
//   hex_codes  - 16-bit value to four display codes, digit0 in [4:0]
package game_pkg;

    typedef enum logic [2:0] {
        S_SET   = 3'd0,
        S_GUESS = 3'd1,
        S_CMP   = 3'd2,
        S_HINT  = 3'd3,
        S_WIN   = 3'd4
    } state_t;

    localparam logic [4:0] CODE_BLANK = 5'd0;
    localparam logic [4:0] CODE_P     = 5'd17;
    localparam logic [4:0] CODE_L     = 5'd18;
    localparam logic [4:0] CODE_H     = 5'd19;

    function automatic logic [4:0] nib2code(input logic [3:0] nib);
        return {1'b0, nib} + 5'd1;
    endfunction

    function automatic logic [19:0] hex_codes(input logic [15:0] val);
        return {nib2code(val[15:12]), nib2code(val[11:8]),
                nib2code(val[7:4]),   nib2code(val[3:0])};
    endfunction

endpackage

// File: rtl/game_tick_timer.sv
// game_tick_timer: counts tick strobes while not cleared and pulses done on
// the TERM-th one, then starts over from zero.
//   clk, rst - clock, asynchronous active-high reset
//   clear    - holds the count at zero; a tick seen while clear is high is dropped
//   tick     - enable strobe to count
//   done     - single-cycle pulse, combinational from the count and tick
module game_tick_timer #(
    parameter int TERM = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic done
);

    localparam int CW = (TERM > 1) ? $clog2(TERM) : 1;
    localparam logic [CW-1:0] LAST = CW'(TERM - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_r;

    assign done = tick & ~clear & (cnt_r == LAST);

    // Tick counter: zero while cleared, wraps to zero on the terminal tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear) begin
            cnt_r <= {CW{1'b0}};
        end else if (tick) begin
            cnt_r <= done ? {CW{1'b0}} : (cnt_r + ONE);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/guess_round_controller.sv
// guess_round_controller: sequences one two-player guessing round.
// Player 1 keys a 4-nibble secret in the set phase, player 2 keys guesses in
// the guess phase; each guess is compared and either a high/low hint screen
// or the win screen with the attempt count and a flashing LED follows.
//   clk, rst   - clock, asynchronous active-high reset
//   tick       - slow strobe used for hint timeout and LED flashing
//   digit_we   - write digit_val into entry nibble digit_sel (0 = rightmost)
//   commit     - confirm the current entry; wins over a same-cycle digit_we
//   disp_codes - four registered 5-bit display codes, digit0 in [4:0]
//   state_o    - current FSM state
//   win        - high while in WIN
//   led_flash  - blink phase in WIN, 0 elsewhere
//   attempts   - committed guesses this round, saturating
module guess_round_controller
    import game_pkg::*;
#(
    parameter int HINT_TICKS  = 3,
    parameter int FLASH_TICKS = 4,
    parameter int ATT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             digit_we,
    input  logic [1:0]       digit_sel,
    input  logic [3:0]       digit_val,
    input  logic             commit,
    output logic [19:0]      disp_codes,
    output logic [2:0]       state_o,
    output logic             win,
    output logic             led_flash,
    output logic [ATT_W-1:0] attempts
);

    localparam int HINT_TERM = HINT_TICKS;

    localparam logic [ATT_W-1:0] ATT_ZERO = {ATT_W{1'b0}};
    localparam logic [ATT_W-1:0] ATT_ONE  = {{(ATT_W-1){1'b0}}, 1'b1};
    localparam logic [ATT_W-1:0] ATT_MAX  = {ATT_W{1'b1}};

    state_t           state_r, state_nxt_s;
    logic [15:0]      entry_r, entry_nxt_s, entry_wr_s;
    logic [15:0]      secret_r, secret_nxt_s;
    logic [15:0]      guess_r, guess_nxt_s;
    logic [ATT_W-1:0] attempts_r, attempts_nxt_s;
    logic             hint_hi_r, hint_hi_nxt_s;
    logic             led_r, led_nxt_s;
    logic             win_r;
    logic [19:0]      disp_r, disp_nxt_s;
    logic [15:0]      att16_s;
    logic             hint_done_s, flash_done_s;

    // Each timer is held clear outside its own state, so a tick arriving on
    // the cycle a state is entered is never counted.
    game_tick_timer #(.TERM(HINT_TERM)) u_hint_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (state_r != S_HINT),
        .tick  (tick),
        .done  (hint_done_s)
    );

    game_tick_timer #(.TERM(FLASH_TICKS)) u_flash_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (state_r != S_WIN),
        .tick  (tick),
        .done  (flash_done_s)
    );

    // Low 16 bits of the attempt counter for the win screen.
    generate
        if (ATT_W >= 16) begin : g_att_wide
            assign att16_s = attempts_r[15:0];
        end else begin : g_att_narrow
            assign att16_s = {{(16-ATT_W){1'b0}}, attempts_r};
        end
    endgenerate

    // Entry buffer with the requested nibble replaced.
    always_comb begin
        entry_wr_s = entry_r;
        entry_wr_s[{digit_sel, 2'b00} +: 4] = digit_val;
    end

    // Next-state and datapath updates for the round FSM.
    always_comb begin
        state_nxt_s    = state_r;
        entry_nxt_s    = entry_r;
        secret_nxt_s   = secret_r;
        guess_nxt_s    = guess_r;
        attempts_nxt_s = attempts_r;
        hint_hi_nxt_s  = hint_hi_r;
        led_nxt_s      = led_r;
        case (state_r)
            S_SET: begin
                if (commit) begin
                    secret_nxt_s = entry_r;
                    entry_nxt_s  = 16'h0000;
                    state_nxt_s  = S_GUESS;
                end else if (digit_we) begin
                    entry_nxt_s = entry_wr_s;
                end else begin
                    state_nxt_s = S_SET;
                end
            end
            S_GUESS: begin
                if (commit) begin
                    guess_nxt_s    = entry_r;
                    attempts_nxt_s = (attempts_r == ATT_MAX) ? attempts_r
                                                             : (attempts_r + ATT_ONE);
                    state_nxt_s    = S_CMP;
                end else if (digit_we) begin
                    entry_nxt_s = entry_wr_s;
                end else begin
                    state_nxt_s = S_GUESS;
                end
            end
            S_CMP: begin
                if (guess_r == secret_r) begin
                    state_nxt_s = S_WIN;
                end else if (guess_r < secret_r) begin
                    state_nxt_s   = S_HINT;
                    hint_hi_nxt_s = 1'b1;
                end else begin
                    state_nxt_s   = S_HINT;
                    hint_hi_nxt_s = 1'b0;
                end
            end
            S_HINT: begin
                // Commit here only dismisses the hint; it is not a guess.
                if (commit) begin
                    state_nxt_s = S_GUESS;
                end else if (digit_we) begin
                    entry_nxt_s = entry_wr_s;
                    state_nxt_s = S_GUESS;
                end else if (hint_done_s) begin
                    state_nxt_s = S_GUESS;
                end else begin
                    state_nxt_s = S_HINT;
                end
            end
            S_WIN: begin
                if (commit) begin
                    entry_nxt_s    = 16'h0000;
                    secret_nxt_s   = 16'h0000;
                    attempts_nxt_s = ATT_ZERO;
                    led_nxt_s      = 1'b0;
                    state_nxt_s    = S_SET;
                end else if (flash_done_s) begin
                    led_nxt_s = ~led_r;
                end else begin
                    led_nxt_s = led_r;
                end
            end
            default: begin
                state_nxt_s = S_SET;
                led_nxt_s   = 1'b0;
            end
        endcase
    end

    // Display codes derived from the current (registered) state, so the
    // display trails a state or entry change by one clock.
    always_comb begin
        disp_nxt_s = hex_codes(entry_r);
        case (state_r)
            S_SET, S_GUESS, S_CMP: disp_nxt_s = hex_codes(entry_r);
            S_HINT:  disp_nxt_s = {(hint_hi_r ? CODE_H : CODE_L),
                                   CODE_BLANK, CODE_BLANK, CODE_BLANK};
            S_WIN:   disp_nxt_s = hex_codes(att16_s);
            default: disp_nxt_s = hex_codes(entry_r);
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_SET;
            entry_r    <= 16'h0000;
            secret_r   <= 16'h0000;
            guess_r    <= 16'h0000;
            attempts_r <= ATT_ZERO;
            hint_hi_r  <= 1'b0;
            led_r      <= 1'b0;
            win_r      <= 1'b0;
            disp_r     <= 20'h08421;
        end else begin
            state_r    <= state_nxt_s;
            entry_r    <= entry_nxt_s;
            secret_r   <= secret_nxt_s;
            guess_r    <= guess_nxt_s;
            attempts_r <= attempts_nxt_s;
            hint_hi_r  <= hint_hi_nxt_s;
            led_r      <= led_nxt_s;
            win_r      <= (state_nxt_s == S_WIN);
            disp_r     <= disp_nxt_s;
        end
    end

    assign state_o    = state_r;
    assign win        = win_r;
    assign led_flash  = led_r;
    assign attempts   = attempts_r;
    assign disp_codes = disp_r;

endmodule

// File: tb/tb_guess_round_controller.sv
// Self-checking bench for guess_round_controller. Two instances share stimulus:
// the default 16-bit attempt counter and a 4-bit one that reaches saturation.
// A transaction-level model of the round pushes expectations into a queue;
// a monitor pops and compares them on the sampling cycle they name.
module tb_guess_round_controller;

    localparam int P_SET = 0, P_GUESS = 1, P_CMP = 2, P_HINT = 3, P_WIN = 4;
    localparam int HT = 3, FT = 4, SMALL_MAX = 15, BIG_MAX = 65535;

    logic        clk, rst, tick, digit_we, commit;
    logic [1:0]  digit_sel;
    logic [3:0]  digit_val;
    logic [19:0] disp_codes, disp_s;
    logic [2:0]  state_o, state_s;
    logic        win, win_s, led_flash, led_s;
    logic [15:0] attempts;
    logic [3:0]  attempts_s;

    guess_round_controller #(.HINT_TICKS(HT), .FLASH_TICKS(FT), .ATT_W(16)) dut (
        .clk(clk), .rst(rst), .tick(tick), .digit_we(digit_we), .digit_sel(digit_sel),
        .digit_val(digit_val), .commit(commit), .disp_codes(disp_codes),
        .state_o(state_o), .win(win), .led_flash(led_flash), .attempts(attempts));

    guess_round_controller #(.HINT_TICKS(HT), .FLASH_TICKS(FT), .ATT_W(4)) dut_small (
        .clk(clk), .rst(rst), .tick(tick), .digit_we(digit_we), .digit_sel(digit_sel),
        .digit_val(digit_val), .commit(commit), .disp_codes(disp_s),
        .state_o(state_s), .win(win_s), .led_flash(led_s), .attempts(attempts_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (round-level) ----------------
    int          m_phase, m_att, m_hticks, m_fticks;
    logic [15:0] m_entry, m_secret;
    bit          m_hint_hi, m_led;

    typedef struct {
        int          cyc;
        bit          full;
        string       name;
        int          st;
        int          att;
        int          att_s;
        logic [19:0] disp;
        logic [19:0] disp_sm;
        bit          win;
        bit          led;
    } exp_t;

    exp_t sb_q[$];
    int   cycn = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    function automatic logic [19:0] hex_codes(input int v);
        logic [19:0] r;
        for (int i = 0; i < 4; i++) r[i*5 +: 5] = 5'((v >> (4*i)) & 15) + 5'd1;
        return r;
    endfunction

    function logic [19:0] exp_disp(input int att);
        case (m_phase)
            P_SET, P_GUESS: return hex_codes(int'(m_entry));
            P_HINT:         return {(m_hint_hi ? 5'd19 : 5'd18), 15'd0};
            P_WIN:          return hex_codes(att);
            default:        return 20'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = P_SET; m_att = 0; m_hticks = 0; m_fticks = 0;
        m_entry = 16'h0; m_secret = 16'h0; m_hint_hi = 1'b0; m_led = 1'b0;
    endtask

    task automatic model_write(input int sel, input int val);
        m_entry[sel*4 +: 4] = 4'(val);
    endtask

    task automatic model_step(input bit we, input int sel, input int val,
                              input bit cm, input bit tk);
        case (m_phase)
            P_SET: begin
                if (cm) begin m_secret = m_entry; m_entry = 16'h0; m_phase = P_GUESS; end
                else if (we) model_write(sel, val);
            end
            P_GUESS: begin
                if (cm) begin
                    m_att++;
                    if (m_entry == m_secret) begin
                        m_phase = P_WIN; m_fticks = 0; m_led = 1'b0;
                    end else begin
                        m_phase = P_HINT; m_hticks = 0; m_hint_hi = (m_entry < m_secret);
                    end
                end else if (we) model_write(sel, val);
            end
            P_HINT: begin
                if (cm) m_phase = P_GUESS;
                else if (we) begin model_write(sel, val); m_phase = P_GUESS; end
                else if (tk) begin
                    m_hticks++;
                    if (m_hticks == HT) m_phase = P_GUESS;
                end
            end
            P_WIN: begin
                if (cm) begin
                    m_entry = 16'h0; m_secret = 16'h0; m_att = 0; m_led = 1'b0; m_phase = P_SET;
                end else if (tk) begin
                    m_fticks++;
                    if (m_fticks % FT == 0) m_led = !m_led;
                end
            end
            default: m_phase = P_SET;
        endcase
    endtask

    // ---------------- scoreboard ----------------
    task automatic push_state(input int c, input int st, input string nm);
        exp_t e;
        e.cyc = c; e.full = 1'b0; e.name = nm; e.st = st; e.att = 0; e.att_s = 0;
        e.disp = 20'd0; e.disp_sm = 20'd0; e.win = 1'b0; e.led = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic push_full(input string nm);
        exp_t e;
        e.cyc = cycn + 1; e.full = 1'b1; e.name = nm; e.st = m_phase;
        e.att   = (m_att > BIG_MAX) ? BIG_MAX : m_att;
        e.att_s = (m_att > SMALL_MAX) ? SMALL_MAX : m_att;
        e.disp = exp_disp(e.att); e.disp_sm = exp_disp(e.att_s);
        e.win = (m_phase == P_WIN); e.led = m_led;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string nm, input string what, input longint act, input longint want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s.%s: dut=%0h model=%0h", nm, what, act, want);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycn++;
            while (sb_q.size() > 0 && sb_q[0].cyc <= cycn) begin
                e = sb_q.pop_front();
                chk(e.name, "state", longint'(state_o), longint'(e.st));
                chk(e.name, "state_s", longint'(state_s), longint'(e.st));
                if (e.full) begin
                    chk(e.name, "attempts", longint'(attempts), longint'(e.att));
                    chk(e.name, "disp", longint'(disp_codes), longint'(e.disp));
                    chk(e.name, "win", longint'(win), longint'(e.win));
                    chk(e.name, "led", longint'(led_flash), longint'(e.led));
                    chk(e.name, "attempts_s", longint'(attempts_s), longint'(e.att_s));
                    chk(e.name, "disp_s", longint'(disp_s), longint'(e.disp_sm));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_inputs();
        digit_we = 1'b0; commit = 1'b0; tick = 1'b0; digit_sel = 2'd0; digit_val = 4'd0;
    endtask

    task automatic apply_op(input bit we, input int sel, input int val,
                            input bit cm, input bit tk, input string nm);
        @(negedge clk);
        digit_we = we; digit_sel = 2'(sel); digit_val = 4'(val); commit = cm; tick = tk;
        @(negedge clk);
        clear_inputs();
        model_step(we, sel, val, cm, tk);
        repeat (2) @(negedge clk);
        push_full(nm);
        @(negedge clk);
    endtask

    task automatic write_word(input int v, input string nm);
        for (int i = 3; i >= 0; i--) apply_op(1'b1, i, (v >> (4*i)) & 15, 1'b0, 1'b0, nm);
    endtask

    // Commit a guess and check CMP one clock later, HINT/WIN two clocks later.
    task automatic commit_latency(input string nm);
        int k;
        @(negedge clk);
        commit = 1'b1;
        k = cycn;
        push_state(k + 1, P_CMP, {nm, "_cmp"});
        model_step(1'b0, 0, 0, 1'b1, 1'b0);
        push_state(k + 2, m_phase, {nm, "_next"});
        @(negedge clk);
        clear_inputs();
        repeat (2) @(negedge clk);
        push_full(nm);
        @(negedge clk);
    endtask

    // Commit a guess, then tick during CMP: that tick must not count in HINT.
    task automatic commit_then_tick(input string nm);
        @(negedge clk);
        commit = 1'b1;
        model_step(1'b0, 0, 0, 1'b1, 1'b0);
        @(negedge clk);
        commit = 1'b0; tick = 1'b1;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        push_full(nm);
        @(negedge clk);
    endtask

    task automatic reset_check(input string nm);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        push_full(nm);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int r;
        rst = 1'b1;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        push_full("reset_init");
        @(negedge clk);
        rst = 1'b0;

        // Correct first guess.
        write_word(32'h1234, "set_1234");
        apply_op(1'b0, 0, 0, 1'b1, 1'b0, "set_commit");
        write_word(32'h1234, "guess_1234");
        commit_latency("win_first_try");
        for (int i = 0; i < 8; i++) apply_op(1'b0, 0, 0, 1'b0, 1'b1, "win_flash");
        apply_op(1'b0, 0, 0, 1'b1, 1'b0, "win_exit");

        // High/low hints, timeout, write-out and commit-over-write.
        write_word(32'h5000, "set_5000");
        apply_op(1'b0, 0, 0, 1'b1, 1'b0, "set_commit2");
        write_word(32'h4FFF, "guess_4fff");
        commit_latency("hint_high");
        for (int i = 0; i < HT; i++) apply_op(1'b0, 0, 0, 1'b0, 1'b1, "hint_timeout");
        write_word(32'h5001, "guess_5001");
        commit_latency("hint_low");
        apply_op(1'b1, 0, 7, 1'b0, 1'b0, "hint_write_exit");
        apply_op(1'b1, 0, 0, 1'b1, 1'b0, "commit_and_write");
        apply_op(1'b0, 0, 0, 1'b1, 1'b0, "hint_commit");
        reset_check("reset_mid_guess");

        // Tick during CMP not counted; 4-bit counter saturation.
        write_word(32'h0800, "set_0800");
        apply_op(1'b0, 0, 0, 1'b1, 1'b0, "set_commit3");
        commit_then_tick("cmp_tick");
        for (int i = 0; i < HT; i++) apply_op(1'b0, 0, 0, 1'b0, 1'b1, "hint_count");
        for (int i = 0; i < 16; i++) begin
            apply_op(1'b0, 0, 0, 1'b1, 1'b0, "sat_guess");
            apply_op(1'b0, 0, 0, 1'b1, 1'b0, "sat_dismiss");
        end
        write_word(32'h0800, "guess_0800");
        commit_latency("win_saturated");
        apply_op(1'b0, 0, 0, 1'b1, 1'b0, "win_exit2");

        // Randomized play.
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 30)
                apply_op(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                         1'b0, 1'b0, "rnd_write");
            else if (r < 45)
                apply_op(1'b0, 0, 0, 1'b1, 1'b0, "rnd_commit");
            else if (r < 50)
                apply_op(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                         1'b1, 1'b0, "rnd_commit_write");
            else if (r < 80)
                apply_op(1'b0, 0, 0, 1'b0, 1'b1, "rnd_tick");
            else begin
                int s;
                s = int'($urandom_range(0, 3));
                apply_op(1'b1, s, int'(m_secret[s*4 +: 4]), 1'b0, 1'b0, "rnd_write_secret");
            end
        end

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
